// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM
// stage and a multi-cycle line-wide data memory. Hits are served with no
// stall. On a miss, a dirty victim is written back and then the line is
// refilled.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   cpu_addr_i          byte address (word aligned), held while stalled
//   cpu_data_i          store data
//   cpu_MemRead_i       load request
//   cpu_MemWrite_i      store request (wins if both are set)
//   cpu_data_o          load data, 0 unless read hit
//   cpu_stall_o         pipeline freeze
//   mem_enable_o        memory request valid
//   mem_write_o         1 = line write-back, 0 = line refill
//   mem_addr_o          line-aligned memory address
//   mem_data_o          victim line data
//   mem_data_i          refill line data
//   mem_ack_i           one-cycle transfer-complete pulse
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int WORD_BITS   = OFFSET_BITS - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]   data_q [NUM_LINES];

    logic [INDEX_BITS-1:0]  idx_s;
    logic [TAG_BITS-1:0]    req_tag_s;
    logic [WORD_BITS+4:0]   bit_off_s;
    logic                   req_s;
    logic                   hit_s;
    logic                   wr_hit_s;
    logic                   rd_hit_s;
    logic                   refill_s;
    logic                   addr_unused_s;

    assign idx_s         = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign req_tag_s     = cpu_addr_i[31 -: TAG_BITS];
    assign bit_off_s     = {cpu_addr_i[2 +: WORD_BITS], 5'd0};
    assign addr_unused_s = ^cpu_addr_i[1:0];

    assign req_s    = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit_s    = valid_q[idx_s] & (tag_q[idx_s] == req_tag_s);
    // Hits only act in IDLE; a write takes priority over a simultaneous read.
    assign wr_hit_s = (state_q == ST_IDLE) & cpu_MemWrite_i & hit_s;
    assign rd_hit_s = (state_q == ST_IDLE) & cpu_MemRead_i & ~cpu_MemWrite_i & hit_s;
    assign refill_s = (state_q == ST_ALLOCATE) & mem_ack_i;

    // Next-state logic of the miss-handling FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && !hit_s) begin
                    if (valid_q[idx_s] && dirty_q[idx_s]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_ALLOCATE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = ST_ALLOCATE;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and per-line valid/dirty bits; reset discards all lines.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (wr_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end else if (refill_s) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until the line is valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_hit_s) begin
            data_q[idx_s][bit_off_s +: 32] <= cpu_data_i;
        end
        if (!rst_i && refill_s) begin
            data_q[idx_s] <= mem_data_i;
            tag_q[idx_s]  <= req_tag_s;
        end
    end

    // Memory request outputs decoded from the state register only.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx_s], idx_s, {OFFSET_BITS{1'b0}}};
                mem_data_o   = data_q[idx_s];
            end
            ST_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b0;
                mem_addr_o   = {req_tag_s, idx_s, {OFFSET_BITS{1'b0}}};
            end
            default: begin
                mem_enable_o = 1'b0;
            end
        endcase
    end

    // CPU-side read data and stall; both must be combinational for 0-cycle hits.
    always_comb begin
        if (rd_hit_s) begin
            cpu_data_o = data_q[idx_s][bit_off_s +: 32];
        end else begin
            cpu_data_o = 32'd0;
        end
        cpu_stall_o = (state_q != ST_IDLE) | (req_s & ~hit_s);
    end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_cmp = 0;
    int n_mis = 0;
    int stall_cnt;
    logic [255:0] line1, line2, line3, exp_line;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the active edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line1[i*32 +: 32] = 32'(32'h1111_1111 * (i + 1));
            line2[i*32 +: 32] = 32'(32'hA000_0000 + i);
            line3[i*32 +: 32] = 32'(32'h3000_0000 + i);
        end

        rst_i = 1'b1; cpu_addr_i = 32'd0; cpu_data_i = 32'd0;
        cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        next_cycle(); next_cycle();
        rst_i = 1'b0;
        sample();
        check("rst_stall", cpu_stall_o, 0);
        check("rst_data", cpu_data_o, 0);
        check("rst_en", mem_enable_o, 0);
        check("rst_wr", mem_write_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_mdata", mem_data_o, 0);

        // Test 1: clean read miss to 0x40, ack at cycle 10
        next_cycle(); cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h40;
        sample();
        stall_cnt = 0;
        if (cpu_stall_o) stall_cnt++;
        check("t1_c0_stall", cpu_stall_o, 1);
        check("t1_c0_en", mem_enable_o, 0);
        next_cycle(); sample();
        if (cpu_stall_o) stall_cnt++;
        check("t1_alloc_en", mem_enable_o, 1);
        check("t1_alloc_wr", mem_write_o, 0);
        check("t1_alloc_addr", mem_addr_o, 32'h40);
        for (int c = 2; c <= 10; c++) begin
            next_cycle();
            if (c == 10) begin
                mem_ack_i = 1'b1; mem_data_i = line1;
            end
            sample();
            if (cpu_stall_o) stall_cnt++;
        end
        next_cycle(); mem_ack_i = 1'b0; mem_data_i = '0;
        sample();
        if (cpu_stall_o) stall_cnt++;
        check("t1_stall_cycles", stall_cnt, 11);
        check("t1_hit_stall", cpu_stall_o, 0);
        check("t1_hit_data", cpu_data_o, 32'h1111_1111);
        check("t1_idle_en", mem_enable_o, 0);

        // Test 2: read hit on word1
        next_cycle(); cpu_addr_i = 32'h44;
        sample();
        check("t2_stall", cpu_stall_o, 0);
        check("t2_data", cpu_data_o, 32'h2222_2222);

        // Test 3: write hit then read back
        next_cycle(); cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1;
        cpu_addr_i = 32'h48; cpu_data_i = 32'hDEAD_BEEF;
        sample();
        check("t3_wr_stall", cpu_stall_o, 0);
        check("t3_wr_data_o", cpu_data_o, 0);
        next_cycle(); cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1;
        sample();
        check("t3_rd_stall", cpu_stall_o, 0);
        check("t3_rd_data", cpu_data_o, 32'hDEAD_BEEF);

        // Test 4: dirty conflict miss at 0x440
        exp_line = line1;
        exp_line[95:64] = 32'hDEAD_BEEF;
        next_cycle(); cpu_addr_i = 32'h440;
        sample();
        check("t4_c0_stall", cpu_stall_o, 1);
        check("t4_c0_en", mem_enable_o, 0);
        next_cycle(); sample();
        check("t4_wb_en", mem_enable_o, 1);
        check("t4_wb_wr", mem_write_o, 1);
        check("t4_wb_addr", mem_addr_o, 32'h40);
        check("t4_wb_word2", mem_data_o[95:64], 32'hDEAD_BEEF);
        check("t4_wb_line", mem_data_o, exp_line);
        next_cycle(); sample();
        check("t4_wb_hold", mem_write_o, 1);
        next_cycle(); mem_ack_i = 1'b1;
        sample();
        check("t4_wb_ackcyc", mem_write_o, 1);
        next_cycle(); mem_ack_i = 1'b0;
        sample();
        check("t4_al_en", mem_enable_o, 1);
        check("t4_al_wr", mem_write_o, 0);
        check("t4_al_addr", mem_addr_o, 32'h440);
        check("t4_al_stall", cpu_stall_o, 1);
        next_cycle(); mem_ack_i = 1'b1; mem_data_i = line2;
        sample();
        check("t4_al_ack_stall", cpu_stall_o, 1);
        next_cycle(); mem_ack_i = 1'b0;
        sample();
        check("t4_done_stall", cpu_stall_o, 0);
        check("t4_done_data", cpu_data_o, 32'hA000_0000);

        // Test 5: write miss to clean index 4, ack on the first ALLOCATE cycle
        next_cycle(); cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1;
        cpu_addr_i = 32'h80; cpu_data_i = 32'hCAFE_F00D;
        sample();
        check("t5_c0_stall", cpu_stall_o, 1);
        check("t5_c0_en", mem_enable_o, 0);
        next_cycle(); mem_ack_i = 1'b1; mem_data_i = line3;
        sample();
        check("t5_al_en", mem_enable_o, 1);
        check("t5_al_wr", mem_write_o, 0);
        check("t5_al_addr", mem_addr_o, 32'h80);
        next_cycle(); mem_ack_i = 1'b0;
        sample();
        check("t5_merge_stall", cpu_stall_o, 0);
        next_cycle(); cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1;
        sample();
        check("t5_rd_data", cpu_data_o, 32'hCAFE_F00D);
        check("t5_rd_stall", cpu_stall_o, 0);
        // Conflict read proves the merged line is dirty
        exp_line = line3;
        exp_line[31:0] = 32'hCAFE_F00D;
        next_cycle(); cpu_addr_i = 32'h480;
        sample();
        check("t5_miss_stall", cpu_stall_o, 1);
        next_cycle(); sample();
        check("t5_wb_wr", mem_write_o, 1);
        check("t5_wb_addr", mem_addr_o, 32'h80);
        check("t5_wb_line", mem_data_o, exp_line);
        next_cycle(); mem_ack_i = 1'b1;
        sample();
        next_cycle(); mem_ack_i = 1'b0;
        sample();
        check("t6_al1_wr", mem_write_o, 0);
        check("t6_al1_addr", mem_addr_o, 32'h480);

        // Test 6: reset in the third ALLOCATE cycle
        next_cycle(); sample();
        check("t6_al2_en", mem_enable_o, 1);
        next_cycle(); rst_i = 1'b1;
        sample();
        check("t6_al3_en", mem_enable_o, 1);
        next_cycle(); rst_i = 1'b0; cpu_MemRead_i = 1'b0;
        sample();
        check("t6_post_en", mem_enable_o, 0);
        check("t6_post_stall", cpu_stall_o, 0);
        next_cycle(); mem_ack_i = 1'b1; mem_data_i = line3;
        sample();
        check("t6_lateack_en", mem_enable_o, 0);
        check("t6_lateack_stall", cpu_stall_o, 0);
        next_cycle(); mem_ack_i = 1'b0; cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h480;
        sample();
        check("t6_480_miss", cpu_stall_o, 1);
        check("t6_480_data", cpu_data_o, 0);
        next_cycle(); cpu_MemRead_i = 1'b0;
        sample();
        check("t6_480_clean", mem_write_o, 0);
        next_cycle(); mem_ack_i = 1'b1; mem_data_i = line3;
        sample();
        next_cycle(); mem_ack_i = 1'b0; cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h40;
        sample();
        check("t6_40_miss", cpu_stall_o, 1);
        check("t6_40_data", cpu_data_o, 0);
        next_cycle(); sample();
        check("t6_40_en", mem_enable_o, 1);
        check("t6_40_wr", mem_write_o, 0);
        check("t6_40_addr", mem_addr_o, 32'h40);
        next_cycle(); mem_ack_i = 1'b1; mem_data_i = line1;
        sample();
        next_cycle(); mem_ack_i = 1'b0;
        sample();
        check("t6_40_stall", cpu_stall_o, 0);
        check("t6_40_hit", cpu_data_o, 32'h1111_1111);
        next_cycle(); cpu_MemRead_i = 1'b0;
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
